// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// The fetch stage is the master: it raises requests and consumes read data.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single outstanding imem request, branch redirect,
// and a one-entry skid buffer that absorbs a response arriving while decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_pc,
  input  logic [31:0]          imm_ext,
  output logic [31:0]          instr_d,
  output logic [6:0]           op_d,
  output logic [31:0]          pc_d,
  output logic [31:0]          pc_plus4_d,
  output logic                 valid_d
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2,
    BUF   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_req_q, pc_req_d;
  logic [31:0] buf_q, buf_d;
  logic        load;
  logic [31:0] load_data;
  logic [31:0] target;
  logic        req;

  assign target = (branch_pc + imm_ext) & 32'hFFFF_FFFC;

  // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    pc_f_d    = pc_f_q;
    pc_req_d  = pc_req_q;
    buf_d     = buf_q;
    load      = 1'b0;
    load_data = buf_q;
    req       = 1'b0;
    unique case (state_q)
      ISSUE: begin
        req = !rst;
        if (branch_taken) begin
          pc_f_d = target;
          if (imem.imem_gnt) state_d = DROP;
        end else if (imem.imem_gnt) begin
          pc_req_d = pc_f_q;
          pc_f_d   = pc_f_q + 32'd4;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (branch_taken) begin
            pc_f_d  = target;
            state_d = ISSUE;
          end else if (!stall) begin
            load      = 1'b1;
            load_data = imem.imem_rdata;
            state_d   = ISSUE;
          end else begin
            buf_d   = imem.imem_rdata;
            state_d = BUF;
          end
        end else if (branch_taken) begin
          pc_f_d  = target;
          state_d = DROP;
        end
      end
      DROP: begin
        // The in-flight response belongs to the squashed path; only the PC moves.
        if (branch_taken) pc_f_d = target;
        if (imem.imem_rvalid) state_d = ISSUE;
      end
      BUF: begin
        if (branch_taken) begin
          pc_f_d  = target;
          state_d = ISSUE;
        end else if (!stall) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_f_q;
  assign op_d           = instr_d[6:0];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ISSUE;
      pc_f_q     <= RESET_PC;
      pc_req_q   <= 32'h0;
      valid_d    <= 1'b0;
      instr_d    <= 32'h0;
      pc_d       <= 32'h0;
      pc_plus4_d <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_f_q   <= pc_f_d;
      pc_req_q <= pc_req_d;
      if (branch_taken) begin
        valid_d <= 1'b0;
      end else if (load) begin
        instr_d    <= load_data;
        pc_d       <= pc_req_q;
        pc_plus4_d <= pc_req_q + 32'd4;
        valid_d    <= 1'b1;
      end else if (!stall) begin
        valid_d <= 1'b0;
      end
    end
  end

  // NOTE: the buffer data needs no reset; it is only read in BUF, which is entered after a write.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with fixed expectations,
// then randomized traffic compared against a transaction-level reference model.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, branch_taken, gnt, rvalid;
  logic [31:0] branch_pc, imm_ext, rdata;

  fetch_stage_if bus0 ();
  fetch_stage_if bus1 ();

  assign bus0.imem_gnt    = gnt;
  assign bus0.imem_rvalid = rvalid;
  assign bus0.imem_rdata  = rdata;
  assign bus1.imem_gnt    = gnt;
  assign bus1.imem_rvalid = rvalid;
  assign bus1.imem_rdata  = rdata;

  logic [31:0] instr0, pc0, pc4_0, instr1, pc1, pc4_1;
  logic [6:0]  op0, op1;
  logic        valid0, valid1;

  fetch_stage dut0 (
    .clk(clk), .rst(rst), .imem(bus0), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .imm_ext(imm_ext), .instr_d(instr0), .op_d(op0),
    .pc_d(pc0), .pc_plus4_d(pc4_0), .valid_d(valid0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .imem(bus1), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .imm_ext(imm_ext), .instr_d(instr1), .op_d(op1),
    .pc_d(pc1), .pc_plus4_d(pc4_1), .valid_d(valid1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model of dut0 (RESET_PC = 0), tracked as fetch transactions.
  logic [31:0] m_pc, m_out_addr, m_buf_data, m_buf_pc;
  logic        m_out, m_kill, m_buf;
  logic [31:0] e_instr, e_pc, e_pc4;
  logic        e_valid;
  int          mem_cnt;

  function automatic logic exp_req();
    return !rst && !m_out && !m_buf;
  endfunction

  task automatic model_update();
    logic [31:0] tgt;
    logic        ld;
    logic [31:0] ld_data, ld_pc;
    tgt     = (branch_pc + imm_ext) & 32'hFFFF_FFFC;
    ld      = 1'b0;
    ld_data = 32'h0;
    ld_pc   = 32'h0;
    if (rst) begin
      m_pc = 32'h0; m_out = 1'b0; m_kill = 1'b0; m_buf = 1'b0;
      e_valid = 1'b0; e_instr = 32'h0; e_pc = 32'h0; e_pc4 = 32'h0;
    end else begin
      if (exp_req()) begin
        if (gnt) begin
          m_out = 1'b1; m_out_addr = m_pc; m_kill = branch_taken;
        end
        m_pc = branch_taken ? tgt : (gnt ? m_pc + 32'd4 : m_pc);
      end else if (m_out) begin
        if (rvalid) begin
          m_out = 1'b0;
          if (!(m_kill || branch_taken)) begin
            if (!stall) begin
              ld = 1'b1; ld_data = rdata; ld_pc = m_out_addr;
            end else begin
              m_buf = 1'b1; m_buf_data = rdata; m_buf_pc = m_out_addr;
            end
          end
        end else if (branch_taken) begin
          m_kill = 1'b1;
        end
        if (branch_taken) m_pc = tgt;
      end else if (m_buf) begin
        if (branch_taken) begin
          m_buf = 1'b0; m_pc = tgt;
        end else if (!stall) begin
          ld = 1'b1; ld_data = m_buf_data; ld_pc = m_buf_pc; m_buf = 1'b0;
        end
      end
      if (branch_taken) e_valid = 1'b0;
      else if (ld) begin
        e_valid = 1'b1; e_instr = ld_data; e_pc = ld_pc; e_pc4 = ld_pc + 32'd4;
      end else if (!stall) e_valid = 1'b0;
    end
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    branch_pc = 32'h0; imm_ext = 32'h0; rdata = 32'h0;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; #1;
    tests++; if (bus0.imem_req !== 1'b0) begin fails++; $display("FAIL reset_req_low got %0b want 0", bus0.imem_req); end
    tick();
    tests++; if (valid0 !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", valid0); end
    tests++; if (instr0 !== 32'h0 || pc0 !== 32'h0 || pc4_0 !== 32'h0) begin fails++;
      $display("FAIL reset_regs got instr=%h pc=%h pc4=%h want all 0", instr0, pc0, pc4_0); end
    idle(); #1;
    tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0) begin fails++;
      $display("FAIL reset_first_req got req=%0b addr=%h want 1/0", bus0.imem_req, bus0.imem_addr); end
  endtask

  task automatic test_basic_fetch();
    idle(); gnt = 1'b1; #1;
    tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h0) begin fails++;
      $display("FAIL basic_issue got req=%0b addr=%h want 1/0", bus0.imem_req, bus0.imem_addr); end
    tick();
    idle(); #1;
    tests++; if (bus0.imem_req !== 1'b0) begin fails++; $display("FAIL basic_wait_req got %0b want 0", bus0.imem_req); end
    tick();
    idle(); rvalid = 1'b1; rdata = 32'h0050_0093; #1;
    tick();
    tests++; if (instr0 !== 32'h0050_0093 || op0 !== 7'd19 || valid0 !== 1'b1) begin fails++;
      $display("FAIL basic_load got instr=%h op=%0d valid=%0b want 00500093/19/1", instr0, op0, valid0); end
    tests++; if (pc0 !== 32'h0 || pc4_0 !== 32'h4) begin fails++;
      $display("FAIL basic_pc got pc=%h pc4=%h want 0/4", pc0, pc4_0); end
    idle(); #1;
    tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h4) begin fails++;
      $display("FAIL basic_next_addr got req=%0b addr=%h want 1/4", bus0.imem_req, bus0.imem_addr); end
  endtask

  task automatic test_stall_buffer();
    idle(); stall = 1'b1; gnt = 1'b1; #1;
    tick();
    tests++; if (valid0 !== 1'b1 || instr0 !== 32'h0050_0093) begin fails++;
      $display("FAIL stall_hold got valid=%0b instr=%h want 1/00500093", valid0, instr0); end
    idle(); stall = 1'b1; rvalid = 1'b1; rdata = 32'h0000_2183; #1;
    tick();
    #1;
    tests++; if (valid0 !== 1'b1 || instr0 !== 32'h0050_0093 || bus0.imem_req !== 1'b0) begin fails++;
      $display("FAIL stall_buffered got valid=%0b instr=%h req=%0b want 1/00500093/0", valid0, instr0, bus0.imem_req); end
    idle(); #1;
    tick();
    tests++; if (instr0 !== 32'h0000_2183 || op0 !== 7'd3 || valid0 !== 1'b1) begin fails++;
      $display("FAIL stall_release got instr=%h op=%0d valid=%0b want 00002183/3/1", instr0, op0, valid0); end
    tests++; if (pc0 !== 32'h4 || pc4_0 !== 32'h8) begin fails++;
      $display("FAIL stall_release_pc got pc=%h pc4=%h want 4/8", pc0, pc4_0); end
    idle(); #1;
    tick();
    tests++; if (valid0 !== 1'b0 || instr0 !== 32'h0000_2183) begin fails++;
      $display("FAIL bubble got valid=%0b instr=%h want 0/00002183", valid0, instr0); end
  endtask

  task automatic test_branch_wait();
    idle(); gnt = 1'b1; #1;
    tick();
    idle(); branch_taken = 1'b1; branch_pc = 32'h10; imm_ext = 32'hFFFF_FFF8; stall = 1'b1; #1;
    tick();
    idle(); #1;
    tests++; if (valid0 !== 1'b0 || bus0.imem_req !== 1'b0) begin fails++;
      $display("FAIL branch_wait_drop got valid=%0b req=%0b want 0/0", valid0, bus0.imem_req); end
    idle(); rvalid = 1'b1; rdata = 32'hDEAD_BEEF; #1;
    tick();
    tests++; if (valid0 !== 1'b0 || instr0 !== 32'h0000_2183) begin fails++;
      $display("FAIL branch_wait_discard got valid=%0b instr=%h want 0/00002183", valid0, instr0); end
    idle(); #1;
    tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h8) begin fails++;
      $display("FAIL branch_wait_target got req=%0b addr=%h want 1/8", bus0.imem_req, bus0.imem_addr); end
  endtask

  task automatic test_branch_buf();
    idle(); gnt = 1'b1; #1; tick();
    idle(); rvalid = 1'b1; rdata = 32'h1111_1113; #1; tick();
    idle(); stall = 1'b1; gnt = 1'b1; #1; tick();
    idle(); stall = 1'b1; rvalid = 1'b1; rdata = 32'h2222_2223; #1; tick();
    tests++; if (valid0 !== 1'b1 || pc0 !== 32'h8) begin fails++;
      $display("FAIL branch_buf_setup got valid=%0b pc=%h want 1/8", valid0, pc0); end
    idle(); stall = 1'b1; branch_taken = 1'b1; branch_pc = 32'h100; imm_ext = 32'h23; #1;
    tick();
    tests++; if (valid0 !== 1'b0 || instr0 !== 32'h1111_1113) begin fails++;
      $display("FAIL branch_buf_clear got valid=%0b instr=%h want 0/11111113", valid0, instr0); end
    idle(); #1;
    tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h120) begin fails++;
      $display("FAIL branch_buf_target got req=%0b addr=%h want 1/120", bus0.imem_req, bus0.imem_addr); end
    tick();
    tests++; if (valid0 !== 1'b0 || instr0 !== 32'h1111_1113) begin fails++;
      $display("FAIL branch_buf_gone got valid=%0b instr=%h want 0/11111113", valid0, instr0); end
  endtask

  task automatic test_gnt_low();
    for (int i = 0; i < 5; i++) begin
      idle(); #1;
      tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h120) begin fails++;
        $display("FAIL gnt_low_stable cycle %0d got req=%0b addr=%h want 1/120", i, bus0.imem_req, bus0.imem_addr); end
      tick();
      tests++; if (valid0 !== 1'b0) begin fails++; $display("FAIL gnt_low_valid cycle %0d got %0b want 0", i, valid0); end
    end
    idle(); branch_taken = 1'b1; branch_pc = 32'h200; imm_ext = 32'h4; #1;
    tick();
    idle(); #1;
    tests++; if (bus0.imem_req !== 1'b1 || bus0.imem_addr !== 32'h204) begin fails++;
      $display("FAIL issue_branch got req=%0b addr=%h want 1/204", bus0.imem_req, bus0.imem_addr); end
  endtask

  task automatic test_pc_wrap();
    idle(); rst = 1'b1; #1; tick();
    tests++; if (valid0 !== 1'b0 || pc4_0 !== 32'h0) begin fails++;
      $display("FAIL midrun_reset got valid=%0b pc4=%h want 0/0", valid0, pc4_0); end
    idle(); gnt = 1'b1; #1;
    tests++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'hFFFF_FFFC) begin fails++;
      $display("FAIL wrap_first_addr got req=%0b addr=%h want 1/fffffffc", bus1.imem_req, bus1.imem_addr); end
    tick();
    idle(); rvalid = 1'b1; rdata = 32'h0000_0013; #1; tick();
    tests++; if (valid1 !== 1'b1 || pc1 !== 32'hFFFF_FFFC || pc4_1 !== 32'h0 || op1 !== 7'd19) begin fails++;
      $display("FAIL wrap_load got valid=%0b pc=%h pc4=%h op=%0d want 1/fffffffc/0/19", valid1, pc1, pc4_1, op1); end
    idle(); #1;
    tests++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h0) begin fails++;
      $display("FAIL wrap_next_addr got req=%0b addr=%h want 1/0", bus1.imem_req, bus1.imem_addr); end
  endtask

  task automatic test_random();
    logic granted;
    idle(); rst = 1'b1; #1; tick();
    mem_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst          = ($urandom_range(0, 299) == 0);
      stall        = ($urandom_range(0, 9) < 3);
      branch_taken = ($urandom_range(0, 9) == 0);
      branch_pc    = $urandom;
      imm_ext      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
      granted      = exp_req() && ($urandom_range(0, 2) != 0);
      gnt          = granted;
      rvalid       = m_out && (mem_cnt == 1);
      rdata        = $urandom;
      #1;
      tests++; if (bus0.imem_req !== exp_req() || (exp_req() && bus0.imem_addr !== m_pc)) begin fails++;
        $display("FAIL rand_req cycle %0d got req=%0b addr=%h want %0b/%h", i, bus0.imem_req, bus0.imem_addr, exp_req(), m_pc); end
      tick();
      if (rst) mem_cnt = 0;
      else if (granted) mem_cnt = $urandom_range(1, 3);
      else if (mem_cnt > 0) mem_cnt--;
      tests++; if (valid0 !== e_valid || instr0 !== e_instr || op0 !== e_instr[6:0] || pc0 !== e_pc || pc4_0 !== e_pc4) begin fails++;
        $display("FAIL rand_ifid cycle %0d got v=%0b i=%h pc=%h pc4=%h want v=%0b i=%h pc=%h pc4=%h",
                 i, valid0, instr0, pc0, pc4_0, e_valid, e_instr, e_pc, e_pc4); end
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    mem_cnt = 0;
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_stall_buffer();
    test_branch_wait();
    test_branch_buf();
    test_gnt_low();
    test_pc_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
